// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and helpers for the iterative shift-and-add multiplier.
// Holds the FSM state encoding and the iteration-counter width rule.
package mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  // A counter that must hold WIDTH-1 needs at least one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/product valid-ready bundle between an upstream producer,
// the multiplier (slave) and the product consumer.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/shift_add_multiplier_adder.sv
// Catalog adder element: WIDTH-bit ripple add with carry in and carry out.
module catalog_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/shift_add_multiplier_fsm.sv
// Control for the multiplier: state register, iteration counter,
// registered handshake outputs and datapath strobes.
module mul_fsm
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic busy,
  output logic load,
  output logic step,
  output logic finish
);

  localparam int CW = cnt_width(WIDTH);

  mul_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  assign load   = (state_q == IDLE) && in_valid;
  assign step   = (state_q == RUN);
  assign finish = step && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state, so in_ready never sees out_ready combinationally.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned iterative multiplier: one conditional add and right shift per
// cycle over exactly WIDTH cycles, with valid/ready on both sides.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               load;
  logic               step;
  logic               finish;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] shifted;

  mul_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .busy      (bus.busy),
    .load      (load),
    .step      (step),
    .finish    (finish)
  );

  assign addend = acc_lo_q[0] ? mcand_q : '0;

  catalog_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // The adder carry becomes the new MSB, so no partial-product bit is lost.
  assign shifted = {carry, sum, acc_lo_q[WIDTH-1:1]};

  always_comb begin
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    product_d = product_q;
    if (load) begin
      mcand_d  = bus.a;
      acc_hi_d = '0;
      acc_lo_d = bus.b;
    end else if (step) begin
      {acc_hi_d, acc_lo_d} = shifted;
      if (finish) product_d = shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      product_q <= product_d;
    end
  end

  assign bus.product = product_q;

endmodule
